uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, receiver clock at Prescale x bit rate.
REQ-002 SHALL have port RST, input, 1; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port RX_IN, input, 1, serial line, idle high.
REQ-004 SHALL have port PAR_EN, input, 1, parity bit present in frame.
REQ-005 SHALL have port Prescale, input, 6, oversampling ratio; legal values 8, 16, 32.
REQ-006 SHALL have port strt_glitch, input, 1, start-checker error flag.
REQ-007 SHALL have port par_err, input, 1, parity-checker error flag.
REQ-008 SHALL have port stp_err, input, 1, stop-checker error flag.
REQ-009 SHALL have port edge_cnt, output, 5, oversample index within the current bit.
REQ-010 SHALL have port bit_cnt, output, 4, bit index within the frame.
REQ-011 SHALL have ports dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, output, 1 each; sampler, checker and deserializer enables.
REQ-012 SHALL have port data_valid, output, 1, one-cycle frame-accepted pulse.
REQ-013 SHALL have port frame_err, output, 1, one-cycle frame-dropped pulse.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP, DONE in a registered FSM.
REQ-015 SHALL latch Prescale into an internal register on each IDLE->START or DONE->START transition, then use only the latched value (P) until the frame ends.
REQ-016 SHALL hold edge_cnt=0 in IDLE and DONE, make edge_cnt 0 in the first START cycle, increment it by 1 each cycle, and wrap it to 0 after P-1 ("bit end").
REQ-017 SHALL use bit_cnt values START=0, DATA=1..8, PARITY=9, and STOP=9 (PAR_EN=0) or 10 (PAR_EN=1); SHALL increment bit_cnt at each bit end and reset it to 0 in IDLE and DONE.
REQ-018 SHALL move IDLE->START when RX_IN=0, and SHALL stay in IDLE otherwise.
REQ-019 SHALL, in START, assert strt_chk_en and dat_samp_en; at bit end, go to IDLE if strt_glitch=1 (no frame_err), else go to DATA.
REQ-020 SHALL, in DATA, assert dat_samp_en, and assert deser_en for exactly the single cycle where edge_cnt=P-1.
REQ-021 SHALL leave DATA at the bit end where bit_cnt=8: to PARITY if PAR_EN=1, else to STOP.
REQ-022 SHALL, in PARITY, assert dat_samp_en and par_chk_en; at bit end, set an internal err flag if par_err=1, then go to STOP.
REQ-023 SHALL, in STOP, assert dat_samp_en and stp_chk_en; at bit end, go to DONE if stp_err=0 and err flag=0, otherwise pulse frame_err for 1 cycle and go to IDLE.
REQ-024 SHALL, in DONE, assert data_valid for exactly one cycle, then go to START if RX_IN=0 (back-to-back frame), else to IDLE.
REQ-025 SHALL evaluate checker error inputs only in the edge_cnt=P-1 cycle of their own state, and ignore them at all other times.
REQ-026 SHALL sample PAR_EN once, at DATA exit; a PAR_EN change mid-frame SHALL NOT alter the current frame once it has left DATA.
REQ-027 SHALL drive all outputs from registers or from state/edge_cnt decode only, with no combinational path from RX_IN to any output.
REQ-028 SHALL hold all enables low in IDLE and DONE, and SHALL never assert data_valid and frame_err together.

Reset
REQ-029 SHALL, on RST=1 at any time including mid-frame, force state IDLE and force edge_cnt, bit_cnt, all enables, data_valid, frame_err, err flag and latched Prescale to 0.
REQ-030 SHALL resume operation on the first CLK edge after RST deasserts; a frame interrupted by reset SHALL produce neither data_valid nor frame_err.

Verification
REQ-031 SHALL cover: Prescale=8, PAR_EN=1, frame 0xA5 with good parity -> 8 deser_en pulses, data_valid=1 exactly 88 cycles after START entry, frame_err=0.
REQ-032 SHALL cover: Prescale=16, PAR_EN=0, frame 0x3C -> STOP reached at bit_cnt=9, data_valid pulse after 160 START-to-DONE cycles.
REQ-033 SHALL cover: strt_glitch=1 at START edge_cnt=P-1 -> return to IDLE, no deser_en, no data_valid, no frame_err.
REQ-034 SHALL cover: par_err=1 in PARITY, stp_err=0 -> STOP still entered, frame_err pulses once at STOP bit end, data_valid stays 0.
REQ-035 SHALL cover: two back-to-back frames with RX_IN=0 in DONE -> DONE->START directly, two data_valid pulses, Prescale changed 8->32 between frames takes effect only on the second frame.
REQ-036 SHALL cover: RST=1 asserted in DATA at bit_cnt=4 -> all outputs 0 in the same cycle, IDLE held while RX_IN=1 after release.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: sequences start/data/parity/stop bits at the
// latched oversampling ratio and drives sampler, checker and deserializer enables.
module uart_rx_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       deser_en,
    output logic       data_valid,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] prescale_q;
    logic       err_q;
    logic       bit_end;
    logic       pre_bit_end;

    assign bit_end     = ({1'b0, edge_cnt} == (prescale_q - 6'd1));
    assign pre_bit_end = ({1'b0, edge_cnt} == (prescale_q - 6'd2));

    // Enables are registered alongside the state, so they follow the state being entered.
    function automatic logic [3:0] enables_for(input state_t s);
        case (s)
            START:   enables_for = 4'b1001;
            DATA:    enables_for = 4'b0001;
            PARITY:  enables_for = 4'b0101;
            STOP:    enables_for = 4'b0011;
            default: enables_for = 4'b0000;
        endcase
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            prescale_q <= '0;
            err_q      <= 1'b0;
            {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= '0;
            deser_en   <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            deser_en   <= 1'b0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    if (!RX_IN) begin
                        state      <= START;
                        prescale_q <= Prescale;
                        err_q      <= 1'b0;
                        {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= enables_for(START);
                    end else begin
                        state <= IDLE;
                        {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= enables_for(IDLE);
                    end
                end
                START: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        if (strt_glitch) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                            {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= enables_for(IDLE);
                        end else begin
                            state   <= DATA;
                            bit_cnt <= bit_cnt + 4'd1;
                            {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= enables_for(DATA);
                        end
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd8) begin
                            state <= PAR_EN ? PARITY : STOP;
                            {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <=
                                enables_for(PAR_EN ? PARITY : STOP);
                        end
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                        // Raised one cycle early so the pulse lands on the last oversample.
                        deser_en <= pre_bit_end;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        bit_cnt  <= bit_cnt + 4'd1;
                        err_q    <= err_q | par_err;
                        state    <= STOP;
                        {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= enables_for(STOP);
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        edge_cnt <= '0;
                        bit_cnt  <= '0;
                        {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= enables_for(IDLE);
                        if (!stp_err && !err_q) begin
                            state      <= DONE;
                            data_valid <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        edge_cnt <= edge_cnt + 5'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                    bit_cnt  <= '0;
                    {strt_chk_en, par_chk_en, stp_chk_en, dat_samp_en} <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven bit by bit and their expected
// outcome queued; a negedge monitor pops and compares when data_valid/frame_err fires.
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       deser_en;
    logic       data_valid;
    logic       frame_err;

    uart_rx_ctrl dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .Prescale   (Prescale),
        .strt_glitch(strt_glitch),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .edge_cnt   (edge_cnt),
        .bit_cnt    (bit_cnt),
        .dat_samp_en(dat_samp_en),
        .strt_chk_en(strt_chk_en),
        .par_chk_en (par_chk_en),
        .stp_chk_en (stp_chk_en),
        .deser_en   (deser_en),
        .data_valid (data_valid),
        .frame_err  (frame_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;   // 0 = data_valid, 1 = frame_err
        int lat;    // cycles from first START cycle to the pulse
        int deser;  // deser_en pulses in the frame
        int stopb;  // bit_cnt on the first STOP cycle
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   tot_deser = 0;
    int   tot_dv = 0;
    int   tot_fe = 0;
    int   tot_start = 0;
    int   start_gap = 0;
    int   both_seen = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int outs();
        return int'({edge_cnt, bit_cnt, dat_samp_en, strt_chk_en, par_chk_en,
                     stp_chk_en, deser_en, data_valid, frame_err});
    endfunction

    task automatic monitor();
        int   cyc;
        int   t_start;
        int   n_deser;
        int   stop_b;
        int   last_dv;
        exp_t e;
        cyc = 0; t_start = 0; n_deser = 0; stop_b = -1; last_dv = -1000;
        forever begin
            @(negedge CLK);
            cyc++;
            if (deser_en) begin
                n_deser++;
                tot_deser++;
            end
            if (strt_chk_en && edge_cnt == 5'd0) begin
                t_start   = cyc;
                n_deser   = 0;
                stop_b    = -1;
                start_gap = cyc - last_dv;
                tot_start++;
            end
            if (stp_chk_en && stop_b < 0) stop_b = int'(bit_cnt);
            if (data_valid && frame_err) both_seen = 1;
            if (data_valid || frame_err) begin
                if (data_valid) begin
                    tot_dv++;
                    last_dv = cyc;
                    check("done_enables", int'({dat_samp_en, strt_chk_en, par_chk_en,
                                                stp_chk_en, deser_en}), 0);
                end
                if (frame_err) tot_fe++;
                if (sb.size() == 0) begin
                    check("unexpected_output", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("kind", frame_err ? 1 : 0, e.kind);
                    check("latency", cyc - t_start, e.lat);
                    check("deser_count", n_deser, e.deser);
                    check("stop_bit_cnt", stop_b, e.stopb);
                end
            end
        end
    endtask

    // Starts just after a posedge; returns just after the edge that ends the frame in the DUT.
    task automatic send_frame(input int p, input int p_next, input bit pe, input bit pe_drop,
                              input logic [7:0] d, input bit glitch, input bit perr,
                              input bit serr);
        exp_t e;
        if (!glitch) begin
            e.kind  = ((pe && perr) || serr) ? 1 : 0;
            e.lat   = p * (pe ? 11 : 10);
            e.deser = 8;
            e.stopb = pe ? 10 : 9;
            sb.push_back(e);
        end
        Prescale    = 6'(p);
        PAR_EN      = pe;
        RX_IN       = 1'b0;
        strt_glitch = glitch;
        @(posedge CLK);
        repeat (p) @(posedge CLK);
        #1;
        strt_glitch = 1'b0;
        Prescale    = 6'(p_next);
        if (glitch) begin
            RX_IN = 1'b1;
            return;
        end
        for (int i = 0; i < 8; i++) begin
            RX_IN = d[i];
            repeat (p) @(posedge CLK);
            #1;
        end
        if (pe) begin
            if (pe_drop) PAR_EN = 1'b0;
            RX_IN   = (^d) ^ perr;
            par_err = perr;
            repeat (p) @(posedge CLK);
            #1;
            par_err = 1'b0;
        end
        RX_IN   = 1'b1;
        stp_err = serr;
        repeat (p) @(posedge CLK);
        #1;
        stp_err = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge CLK);
        #1;
        check("drain", sb.size(), 0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    initial begin
        int s_deser;
        int s_dv;
        int s_fe;
        int s_start;
        int found;

        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; Prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        fork
            monitor();
        join_none

        #1;
        check("reset_outputs", outs(), 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("idle_hold", outs(), 0);

        // P=8, parity, good frame
        send_frame(8, 8, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
        wait_drain(10);

        // P=16, no parity; par_err held high must be ignored
        par_err = 1'b1;
        send_frame(16, 16, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        par_err = 1'b0;
        wait_drain(10);

        // start glitch
        s_deser = tot_deser; s_dv = tot_dv; s_fe = tot_fe; s_start = tot_start;
        send_frame(8, 8, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (24) @(posedge CLK);
        #1;
        check("glitch_start_seen", tot_start - s_start, 1);
        check("glitch_deser", tot_deser - s_deser, 0);
        check("glitch_dv", tot_dv - s_dv, 0);
        check("glitch_fe", tot_fe - s_fe, 0);
        check("glitch_idle", outs(), 0);

        // parity error; PAR_EN dropped while in PARITY must not change the frame
        send_frame(8, 8, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
        wait_drain(10);

        // stop error
        send_frame(16, 16, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        wait_drain(10);

        // back-to-back, Prescale 8 -> 32 changed mid first frame
        s_dv = tot_dv;
        send_frame(8, 32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(32, 32, 1'b0, 1'b0, 8'h7E, 1'b0, 1'b0, 1'b0);
        wait_drain(10);
        check("b2b_gap", start_gap, 1);
        check("b2b_dv_count", tot_dv - s_dv, 2);

        // reset mid-frame at DATA bit_cnt=4
        s_dv = tot_dv; s_fe = tot_fe;
        Prescale = 6'd16; PAR_EN = 1'b0; RX_IN = 1'b0;
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            @(negedge CLK);
            if (dat_samp_en && !strt_chk_en && bit_cnt == 4'd4) found = 1;
        end
        check("rst_reach_bit4", found, 1);
        #1 RST = 1'b1;
        #1 check("rst_outputs_async", outs(), 0);
        RX_IN = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST = 1'b0;
        repeat (40) @(posedge CLK);
        #1;
        check("rst_idle_hold", outs(), 0);
        check("rst_no_dv", tot_dv - s_dv, 0);
        check("rst_no_fe", tot_fe - s_fe, 0);

        // operation resumes after reset
        send_frame(32, 32, 1'b1, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
        wait_drain(10);

        check("dv_fe_exclusive", both_seen, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
